// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave system bus arbiter with a single outstanding transaction and timeout termination
module bus_arbiter #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int RoundRobin    = 1,
  parameter int TimeoutCycles = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req,
  input  logic                   m0_wr,
  input  logic [AddrWidth-1:0]   m0_addr,
  input  logic [DataWidth-1:0]   m0_wdata,
  input  logic [DataWidth/8-1:0] m0_be,
  output logic                   m0_ack,
  output logic                   m0_err,
  output logic [DataWidth-1:0]   m0_rdata,
  input  logic                   m1_req,
  input  logic                   m1_wr,
  input  logic [AddrWidth-1:0]   m1_addr,
  input  logic [DataWidth-1:0]   m1_wdata,
  input  logic [DataWidth/8-1:0] m1_be,
  output logic                   m1_ack,
  output logic                   m1_err,
  output logic [DataWidth-1:0]   m1_rdata,
  output logic                   s_req,
  output logic                   s_wr,
  output logic [AddrWidth-1:0]   s_addr,
  output logic [DataWidth-1:0]   s_wdata,
  output logic [DataWidth/8-1:0] s_be,
  input  logic                   s_ack,
  input  logic [DataWidth-1:0]   s_rdata,
  output logic [1:0]             grant,
  output logic                   busy
);
  localparam int CW = TimeoutCycles > 1 ? $clog2(TimeoutCycles) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nxt;
  logic last_owner, win1, tmo, done;
  logic [CW-1:0] cnt;
  logic [DataWidth-1:0] rsp_data;
  always_comb begin
    win1 = m1_req & (~m0_req | (RoundRobin != 0 ? ~last_owner : 1'b1));
    tmo = (TimeoutCycles != 0) && (cnt == CntLast);
    done = s_ack | tmo;
    rsp_data = s_ack ? s_rdata : '0;
    state_nxt = state == IDLE  ? ((m0_req | m1_req) ? ISSUE : IDLE) :
                state == ISSUE ? (done ? RESP : ISSUE) : IDLE;
  end
  assign s_req = state == ISSUE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_owner <= 1'b1;
      cnt <= '0;
      grant <= '0;
      s_wr <= 1'b0;
      s_addr <= '0;
      s_wdata <= '0;
      s_be <= '0;
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m0_rdata <= '0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      m1_rdata <= '0;
    end else begin
      state <= state_nxt;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      if (state == IDLE && (m0_req | m1_req)) begin
        grant <= {win1, ~win1};
        last_owner <= win1;
        s_wr <= win1 ? m1_wr : m0_wr;
        s_addr <= win1 ? m1_addr : m0_addr;
        s_wdata <= win1 ? m1_wdata : m0_wdata;
        s_be <= win1 ? m1_be : m0_be;
      end
      if (state == ISSUE) begin
        cnt <= cnt + CW'(1);
        if (done && grant[0]) begin
          m0_ack <= 1'b1;
          m0_err <= ~s_ack;
          m0_rdata <= rsp_data;
        end
        if (done && grant[1]) begin
          m1_ack <= 1'b1;
          m1_err <= ~s_ack;
          m1_rdata <= rsp_data;
        end
      end
      if (state == RESP) begin
        grant <= '0;
        cnt <= '0;
      end
    end
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the core's system bus.
- Master 0 is the core memory path (load/store/fetch).
- Master 1 is the debug-module system bus access path, which serves abstract memory commands issued while the core is running.
- Registers the winning request, drives a single outstanding slave transaction, returns the response to the owner, and terminates hung transactions with a bus error.

Parameters:
AddrWidth, 32, width of address buses
DataWidth, 32, width of data buses (byte enables = DataWidth/8)
RoundRobin, 1, 1: alternate grant on contention; 0: fixed priority, master 1 wins
TimeoutCycles, 255, slave cycles before error termination; 0 disables timeout

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 request; held until m0_ack
m0_wr  in  1  1 write, 0 read
m0_addr  in  AddrWidth  address
m0_wdata  in  DataWidth  write data
m0_be  in  DataWidth/8  byte enables
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  valid with m0_ack; 1 = timeout error
m0_rdata  out  DataWidth  read data, valid with m0_ack
m1_req, m1_wr, m1_addr, m1_wdata, m1_be, m1_ack, m1_err, m1_rdata: identical to the master 0 ports, for master 1
s_req  out  1  slave request
s_wr  out  1  slave write
s_addr  out  AddrWidth  slave address
s_wdata  out  DataWidth  slave write data
s_be  out  DataWidth/8  slave byte enables
s_ack  in  1  slave completion
s_rdata  in  DataWidth  slave read data, valid with s_ack
grant  out  2  one-hot current owner; 0 when idle
busy  out  1  high in ISSUE and RESP

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset:
  - Asserting `rst` forces state IDLE and clears all outputs to 0 immediately (s_*, m*_ack, m*_err, m*_rdata, grant, busy).
  - The timeout counter clears.
  - last_owner resets to master 1, so master 0 wins the first tie.
  - Reset mid-transaction abandons the slave access with no ack to any master.
- FSM: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any req sampled high: select winner, register wr/addr/wdata/be into s_*, set grant, go to ISSUE.
  - Single request: that master wins.
  - Both requesting, RoundRobin=1: the master that is not last_owner wins.
  - Both requesting, RoundRobin=0: master 1 wins.
  - last_owner updates on every grant.
- ISSUE:
  - s_req=1; s_* stable for the whole state.
  - s_ack sampled high: capture s_rdata (writes capture as well; value is don't-care for the master), err=0, go to RESP.
  - Otherwise increment the timeout counter.
  - Counter reaching TimeoutCycles with s_ack low: s_rdata captured as 0, err=1, go to RESP.
  - Net effect: s_req is high for at most TimeoutCycles cycles.
  - s_ack in the final counted cycle wins over timeout.
- RESP:
  - s_req=0; owner's m_ack=1 for exactly one cycle, with m_rdata/m_err.
  - The non-owner's ack, err and rdata stay 0.
  - Then IDLE; grant clears and the counter clears.
- Latency: req sampled at edge 0 gives s_req at cycle 1; s_ack in cycle k gives m_ack in cycle k+1.
  - Minimum request-to-ack is 3 cycles (IDLE, ISSUE, RESP).
- Master rules:
  - A master holds req and its payload stable until ack.
  - The master drops req in the cycle after ack, i.e. the IDLE cycle; req is re-evaluated at the end of IDLE, so back-to-back requests lose no more than one cycle.
  - req dropped during ISSUE does not abort the transaction; the ack is still issued.
- Ordering: changes on the non-owner's request lines during ISSUE/RESP have no effect until the next IDLE.
- s_ack outside ISSUE is ignored.
- m*_rdata and m*_err hold their value after ack until the next completion for that master.

Test Plan:
- Single read: m0 reads 0x100, slave acks 2 cycles after s_req with 0xDEADBEEF -> s_addr=0x100 for 2 cycles; m0_ack pulses 1 cycle with m0_rdata=0xDEADBEEF, m0_err=0; m1_ack stays 0.
- Contention, RoundRobin=1: m0 and m1 request continuously for 4 transactions -> grant sequence m0, m1, m0, m1 with exactly one idle cycle between transactions.
- Fixed priority: RoundRobin=0, both request -> m1 served first; m0 served next.
- Timeout: TimeoutCycles=4, slave never acks -> s_req high exactly 4 cycles; m0_ack with m0_err=1 and m0_rdata=0.
- Timeout boundary: s_ack in the 4th s_req cycle -> normal completion, err=0.
- Reset mid-op: assert rst during ISSUE of an m1 write -> s_req, grant and busy go to 0 asynchronously; no ack. After release, m0 and m1 both request -> m0 granted first.
